sipo_deser: RTL and testbench

Serial-in parallel-out deserializer that sits directly upstream of the team's 4-bit parallel-in parallel-out register.
- Shifts in a gated serial bit stream, MSB first.
- Counts bits and presents each completed WIDTH-bit word on q, with a one-cycle q_valid strobe.
- The downstream PIPO stage samples q on that strobe.

---
 rtl/sipo_deser.sv | 119 +++++++++++
 tb/tb_sipo_deser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// ---------------------------------------------------------------------------
// sipo_deser -- serial-in parallel-out deserializer.
//
// Shifts in a gated serial stream MSB first, counts bits, and presents each
// completed WIDTH-bit word on q together with a one-cycle q_valid strobe.
// The downstream parallel register samples q on that strobe.
//
// Optional feature, selected by the macro SIPO_PARITY_CHECK_EN:
//   defined   -> each frame is WIDTH data bits plus one even-parity bit;
//                a bad frame pulses parity_err instead of q_valid.
//   undefined -> frames are WIDTH bits; parity_err is tied low.
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst        in   synchronous active-high reset
//   sin        in   serial data bit (MSB of each word first)
//   sin_valid  in   qualifies sin; a bit is consumed only when high
//   clr        in   synchronous flush of a partially assembled frame
//   q          out  last completed parallel word (held between words)
//   q_valid    out  one-cycle pulse: q was updated at the preceding edge
//   busy       out  high while a frame is partially assembled
//   parity_err out  one-cycle pulse on a parity failure
//
// Handshake: sin/sin_valid is a push-only stream (no ready); q_valid is a
// push-only strobe with no back-pressure from the consumer.
// Priority at each edge: rst > clr > sin_valid.
// ---------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shifted;

    assign shifted = {shreg[WIDTH-2:0], sin};
    assign busy    = (cnt != '0);

`ifdef SIPO_PARITY_CHECK_EN
    // Counter position of the trailing parity bit (data occupy 0..WIDTH-1).
    localparam logic [CW-1:0] PAR_POS = CW'(WIDTH);

    // Even parity over data plus parity bit must come out zero.
    logic parity_ok;
    assign parity_ok = ((^shreg) ^ sin) == 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            q_valid    <= 1'b0;
            parity_err <= 1'b0;
            if (clr) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (sin_valid) begin
                if (cnt == PAR_POS) begin
                    // Parity bit is not shifted in; shreg already holds the data.
                    cnt <= '0;
                    if (parity_ok) begin
                        q       <= shreg;
                        q_valid <= 1'b1;
                    end else begin
                        parity_err <= 1'b1;
                    end
                end else begin
                    shreg <= shifted;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end
`else
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

    assign parity_err = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (clr) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (sin_valid) begin
                shreg <= shifted;
                if (cnt == LAST_DATA) begin
                    q       <= shifted;
                    q_valid <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// ---------------------------------------------------------------------------
// tb_sipo_deser -- scoreboard bench for sipo_deser.
//
// Two instances (WIDTH=4 and WIDTH=8) share one input stream. A reference
// model keeps the bits of the current frame in a queue; when a frame is
// full it packs the data arithmetically, decides parity by counting ones,
// and pushes the expected word (or a parity error) to a queue. A negedge
// monitor pops and compares whenever the DUT strobes, and also checks the
// held q value, busy and parity_err every cycle.
// Honours SIPO_PARITY_CHECK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sipo_deser;

    localparam int W4 = 4;
    localparam int W8 = 8;
`ifdef SIPO_PARITY_CHECK_EN
    localparam int FR4 = W4 + 1;
    localparam int FR8 = W8 + 1;
`else
    localparam int FR4 = W4;
    localparam int FR8 = W8;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic sin = 1'b0;
    logic sin_valid = 1'b0;
    logic clr = 1'b0;

    logic [W4-1:0] q4;
    logic          q_valid4, busy4, parity_err4;
    logic [W8-1:0] q8;
    logic          q_valid8, busy8, parity_err8;

    sipo_deser #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .q(q4), .q_valid(q_valid4), .busy(busy4), .parity_err(parity_err4)
    );

    sipo_deser #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .q(q8), .q_valid(q_valid8), .busy(busy8), .parity_err(parity_err8)
    );

    // ---------------- scoreboard state ----------------
    logic [W4-1:0] exp_q4[$];
    logic [W8-1:0] exp_q8[$];
    logic          b4[$];
    logic          b8[$];
    logic [W4-1:0] qm4;
    logic [W8-1:0] qm8;
    int            perr4 = 0;
    int            perr8 = 0;
    bit            mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic finish4();
        logic [W4-1:0] data = '0;
        int ones = 0;
        for (int i = 0; i < W4; i++) data = (data << 1) | W4'(b4[i]);
        foreach (b4[i]) ones += int'(b4[i]);
        if (ones % 2 == 0 || FR4 == W4) begin
            exp_q4.push_back(data);
            qm4 = data;
        end else begin
            perr4 = 1;
        end
        b4.delete();
    endtask

    task automatic finish8();
        logic [W8-1:0] data = '0;
        int ones = 0;
        for (int i = 0; i < W8; i++) data = (data << 1) | W8'(b8[i]);
        foreach (b8[i]) ones += int'(b8[i]);
        if (ones % 2 == 0 || FR8 == W8) begin
            exp_q8.push_back(data);
            qm8 = data;
        end else begin
            perr8 = 1;
        end
        b8.delete();
    endtask

    task automatic model_step(input logic r, input logic c, input logic v, input logic s);
        if (r) begin
            b4.delete(); b8.delete();
            qm4 = '0; qm8 = '0;
        end else if (c) begin
            b4.delete(); b8.delete();
        end else if (v) begin
            b4.push_back(s);
            b8.push_back(s);
            if (b4.size() == FR4) finish4();
            if (b8.size() == FR8) finish8();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic c, input logic v, input logic s);
        rst = r; clr = c; sin_valid = v; sin = s;
        @(posedge clk);
        model_step(r, c, v, s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, v[i]);
    endtask

    // Sends a nibble plus, in the parity build, its correct even-parity bit.
    task automatic send_word4(input logic [3:0] v);
        send_bits(32'(v), 4);
`ifdef SIPO_PARITY_CHECK_EN
        drive(1'b0, 1'b0, 1'b1, ^v);
`endif
    endtask

    task automatic send_byte8(input logic [7:0] v);
        send_bits(32'(v), 8);
`ifdef SIPO_PARITY_CHECK_EN
        drive(1'b0, 1'b0, 1'b1, ^v);
`endif
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [W4-1:0] w4;
            logic [W8-1:0] w8;
            check("q_valid4", 32'(q_valid4), 32'(exp_q4.size() != 0));
            if (exp_q4.size() != 0) begin
                w4 = exp_q4.pop_front();
                if (q_valid4) check("q4_word", 32'(q4), 32'(w4));
            end
            check("q4_hold", 32'(q4), 32'(qm4));
            check("busy4", 32'(busy4), 32'(b4.size() != 0));
            check("parity_err4", 32'(parity_err4), 32'(perr4 != 0));
            perr4 = 0;

            check("q_valid8", 32'(q_valid8), 32'(exp_q8.size() != 0));
            if (exp_q8.size() != 0) begin
                w8 = exp_q8.pop_front();
                if (q_valid8) check("q8_word", 32'(q8), 32'(w8));
            end
            check("q8_hold", 32'(q8), 32'(qm8));
            check("busy8", 32'(busy8), 32'(b8.size() != 0));
            check("parity_err8", 32'(parity_err8), 32'(perr8 != 0));
            perr8 = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Basic word
        send_word4(4'b1001);
        idle(2);

        // Back-to-back, then a 3-cycle gap after bit 2
        send_word4(4'b1011);
        send_word4(4'b1111);
        idle(1);
        send_bits(32'b10, 2);
        idle(3);
        send_bits(32'b11, 2);
`ifdef SIPO_PARITY_CHECK_EN
        drive(1'b0, 1'b0, 1'b1, 1'b1);
`endif
        idle(2);

        // Flush mid-word, then a clean word
        send_bits(32'b11, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_word4(4'b0110);
        idle(1);

        // clr coinciding with the final bit of the frame: word discarded
        send_bits(32'b1010, FR4 - 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Reset mid-word
        send_word4(4'b1001);
        send_bits(32'b10, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        send_word4(4'b0101);
        idle(2);

`ifdef SIPO_PARITY_CHECK_EN
        // Good parity then bad parity
        send_word4(4'b1011);
        send_bits(32'b1011, 4);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
`endif

        // Byte stream, aligned by a fresh reset
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte8(8'hA5);
        send_byte8(8'h3C);
        idle(2);

        // Randomised phase
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) < 75),
                  1'($urandom_range(0, 1)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
